rvc_asap_5pl_cr_arb: RTL and testbench

RVC_ASAP_5PL_CR_ARB -- requirements
Module: rvc_asap_5pl_cr_arb

---
 rtl/rvc_asap_pkg.sv | 21 ++
 rtl/rvc_asap_5pl_cr_arb.sv | 59 +++++
 tb/tb_rvc_asap_5pl_cr_arb.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/rvc_asap_pkg.sv
// rvc_asap_pkg: shared CR arbiter types, constants and the async-reset flop macro
`ifndef RVC_ASAP_FF_AR
`define RVC_ASAP_FF_AR(clk, rst, q, d, rv) always_ff @(posedge clk or posedge rst) if (rst) q <= (rv); else q <= (d);
`endif

package rvc_asap_pkg;

    localparam logic [1:0] CR_ARB_STARVE_MAX = 2'd3;

    localparam logic [31:0] CR_LED      = 32'h0000_0000;
    localparam logic [31:0] CR_SEG7_0   = 32'h0000_0004;
    localparam logic [31:0] CR_BUTTON_0 = 32'h0000_0008;
    localparam logic [31:0] CR_SWITCH   = 32'h0000_000C;

    typedef enum logic [1:0] {
        CR_ARB_NONE,
        CR_ARB_M0,
        CR_ARB_M1
    } t_cr_arb_owner;

endpackage

// File: rtl/rvc_asap_5pl_cr_arb.sv
// rvc_asap_5pl_cr_arb: two-master CR access arbiter (core priority with debug anti-starvation)
module rvc_asap_5pl_cr_arb
    import rvc_asap_pkg::*;
(
    input  logic        Clock,
    input  logic        Rst,
    input  logic        m0_req,
    input  logic        m0_wren,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_data,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_q,
    input  logic        m1_req,
    input  logic        m1_wren,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_data,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_q,
    output logic        cr_wren,
    output logic        cr_rden,
    output logic [31:0] cr_address,
    output logic [31:0] cr_data,
    input  logic [31:0] cr_q
);

    logic [1:0]    starve_cnt;
    logic [1:0]    starve_cnt_next;
    t_cr_arb_owner owner;
    t_cr_arb_owner owner_next;
    logic          conflict;

    // Grant selection, CR mux and next-state for the starvation counter and read owner
    always_comb begin
        conflict        = m0_req & m1_req;
        m1_gnt          = m1_req & (~m0_req | (starve_cnt == CR_ARB_STARVE_MAX));
        m0_gnt          = m0_req & ~m1_gnt;
        cr_wren         = (m0_gnt & m0_wren) | (m1_gnt & m1_wren);
        cr_rden         = (m0_gnt & ~m0_wren) | (m1_gnt & ~m1_wren);
        cr_address      = m0_gnt ? m0_address : m1_gnt ? m1_address : 32'd0;
        cr_data         = m0_gnt ? m0_data : m1_gnt ? m1_data : 32'd0;
        starve_cnt_next = m1_gnt ? 2'd0 : conflict ? starve_cnt + 2'd1 : starve_cnt;
        owner_next      = (m0_gnt & ~m0_wren) ? CR_ARB_M0 :
                          (m1_gnt & ~m1_wren) ? CR_ARB_M1 : CR_ARB_NONE;
    end

    // Starvation counter: m1 loses at most CR_ARB_STARVE_MAX conflicts in a row
    `RVC_ASAP_FF_AR(Clock, Rst, starve_cnt, starve_cnt_next, 2'd0)

    // Read-return owner: which master receives cr_q in the next cycle
    `RVC_ASAP_FF_AR(Clock, Rst, owner, owner_next, CR_ARB_NONE)

    assign m0_rvalid = (owner == CR_ARB_M0);
    assign m1_rvalid = (owner == CR_ARB_M1);
    assign m0_q      = m0_rvalid ? cr_q : 32'd0;
    assign m1_q      = m1_rvalid ? cr_q : 32'd0;

endmodule

// File: tb/tb_rvc_asap_5pl_cr_arb.sv
// tb_rvc_asap_5pl_cr_arb: directed self-checking bench for the CR arbiter
module tb_rvc_asap_5pl_cr_arb;
    import rvc_asap_pkg::*;

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic        m0_req = 1'b0, m0_wren = 1'b0;
    logic [31:0] m0_address = '0, m0_data = '0;
    logic        m1_req = 1'b0, m1_wren = 1'b0;
    logic [31:0] m1_address = '0, m1_data = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_q, m1_q;
    logic        cr_wren, cr_rden;
    logic [31:0] cr_address, cr_data;
    logic [31:0] cr_q = '0;
    logic [31:0] mem [4];

    int checks = 0;
    int passed = 0;

    rvc_asap_5pl_cr_arb dut (
        .Clock(Clock), .Rst(Rst),
        .m0_req(m0_req), .m0_wren(m0_wren), .m0_address(m0_address), .m0_data(m0_data),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_q(m0_q),
        .m1_req(m1_req), .m1_wren(m1_wren), .m1_address(m1_address), .m1_data(m1_data),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_q(m1_q),
        .cr_wren(cr_wren), .cr_rden(cr_rden), .cr_address(cr_address),
        .cr_data(cr_data), .cr_q(cr_q)
    );

    always #5 Clock = ~Clock;

    // Small CR memory model with one-cycle read latency
    always @(posedge Clock) begin
        if (cr_wren) mem[cr_address[3:2]] <= cr_data;
        if (cr_rden) cr_q <= mem[cr_address[3:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_wren = w0; m0_address = a0; m0_data = d0;
        m1_req = r1; m1_wren = w1; m1_address = a1; m1_data = d1;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        mem[0] = 32'h155;
        mem[1] = 32'h0;
        mem[2] = 32'h1;
        mem[3] = 32'hA5;
        // reset state, with a grant issued during reset
        tick();
        chk("rst_starve", dut.starve_cnt, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        chk("rst_m0_q", m0_q, 0);
        drive(1, 0, CR_LED, 0, 0, 0, 0, 0);
        chk("rst_m0_gnt", m0_gnt, 1);
        tick();
        idle();
        chk("rst_no_rvalid", m0_rvalid, 0);
        Rst = 1'b0;
        tick();
        chk("post_rst_no_rvalid", m0_rvalid, 0);
        // m0 read of LED
        drive(1, 0, CR_LED, 0, 0, 0, 0, 0);
        chk("led_m0_gnt", m0_gnt, 1);
        chk("led_m1_gnt", m1_gnt, 0);
        chk("led_cr_rden", cr_rden, 1);
        chk("led_cr_wren", cr_wren, 0);
        chk("led_cr_addr", cr_address, CR_LED);
        tick();
        idle();
        chk("led_m0_rvalid", m0_rvalid, 1);
        chk("led_m0_q", m0_q, 32'h155);
        chk("led_m1_rvalid", m1_rvalid, 0);
        chk("led_m1_q", m1_q, 0);
        tick();
        chk("led_rvalid_one_cycle", m0_rvalid, 0);
        // m1 write then m0 readback
        drive(0, 0, 0, 0, 1, 1, CR_SEG7_0, 32'h3F);
        chk("seg_m1_gnt", m1_gnt, 1);
        chk("seg_cr_wren", cr_wren, 1);
        chk("seg_cr_rden", cr_rden, 0);
        chk("seg_cr_data", cr_data, 32'h3F);
        chk("seg_cr_addr", cr_address, CR_SEG7_0);
        tick();
        drive(1, 0, CR_SEG7_0, 0, 0, 0, 0, 0);
        chk("seg_wr_no_rvalid0", m0_rvalid, 0);
        chk("seg_wr_no_rvalid1", m1_rvalid, 0);
        chk("seg_rd_gnt", m0_gnt, 1);
        tick();
        idle();
        chk("seg_rd_rvalid", m0_rvalid, 1);
        chk("seg_rd_q", m0_q, 32'h3F);
        tick();
        // back-to-back reads by alternating masters
        drive(1, 0, CR_SWITCH, 0, 0, 0, 0, 0);
        chk("b2b_m0_gnt", m0_gnt, 1);
        tick();
        drive(0, 0, 0, 0, 1, 0, CR_BUTTON_0, 0);
        chk("b2b_m1_gnt", m1_gnt, 1);
        chk("b2b_m0_rvalid", m0_rvalid, 1);
        chk("b2b_m0_q", m0_q, 32'hA5);
        chk("b2b_m1_rvalid_early", m1_rvalid, 0);
        tick();
        idle();
        chk("b2b_m1_rvalid", m1_rvalid, 1);
        chk("b2b_m1_q", m1_q, 32'h1);
        chk("b2b_m0_rvalid_done", m0_rvalid, 0);
        chk("b2b_m0_q_zero", m0_q, 0);
        tick();
        // continuous conflict: m0,m0,m0,m1 repeating
        chk("conf_start_cnt", dut.starve_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, CR_LED, 0, 1, 0, CR_SWITCH, 0);
            chk($sformatf("conf_m1_gnt_%0d", i), m1_gnt, (i % 4) == 3);
            chk($sformatf("conf_m0_gnt_%0d", i), m0_gnt, (i % 4) != 3);
            chk($sformatf("conf_cnt_%0d", i), dut.starve_cnt, i % 4);
            chk($sformatf("conf_addr_%0d", i), cr_address, ((i % 4) == 3) ? CR_SWITCH : CR_LED);
            if (i > 0) chk($sformatf("conf_m1_rvalid_%0d", i), m1_rvalid, (i % 4) == 0);
            tick();
        end
        chk("conf_end_cnt", dut.starve_cnt, 0);
        chk("conf_end_m1_rvalid", m1_rvalid, 1);
        chk("conf_end_m1_q", m1_q, 32'hA5);
        drive(1, 1, CR_LED, 32'h155, 1, 1, CR_LED, 32'hDEAD);
        tick();
        drive(1, 1, CR_LED, 32'h155, 1, 1, CR_LED, 32'hDEAD);
        tick();
        // idle cycles hold the counter and zero the CR bus
        for (int i = 0; i < 5; i++) begin
            idle();
            chk($sformatf("idle_cnt_%0d", i), dut.starve_cnt, 2);
            chk($sformatf("idle_bus_%0d", i), {cr_wren, cr_rden, m0_gnt, m1_gnt}, 0);
            chk($sformatf("idle_addr_%0d", i), cr_address, 0);
            chk($sformatf("idle_data_%0d", i), cr_data, 0);
            tick();
        end
        // reset right after a read grant suppresses its rvalid
        drive(1, 0, CR_LED, 0, 0, 0, 0, 0);
        chk("rr_m0_gnt", m0_gnt, 1);
        tick();
        idle();
        Rst = 1'b1;
        #1;
        chk("rr_rvalid_in_rst", m0_rvalid, 0);
        chk("rr_q_in_rst", m0_q, 0);
        chk("rr_cnt_in_rst", dut.starve_cnt, 0);
        tick();
        Rst = 1'b0;
        #1;
        chk("rr_rvalid_after", m0_rvalid, 0);
        tick();
        chk("rr_rvalid_later", m0_rvalid, 0);
        chk("rr_cnt_after", dut.starve_cnt, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
